// File: rtl/vliw_fetch_if.sv
// Fetch unit bus bundle: instruction-memory request/response, hazard-unit
// controls and the decode-side bundle output.
interface vliw_fetch_if #(
    parameter int XLEN     = 32,
    parameter int BUNDLE_W = 96
) ();
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_req_addr;
    logic                imem_rsp_valid;
    logic [BUNDLE_W-1:0] imem_rsp_bundle;
    logic                stall_in;
    logic                squash_in;
    logic [XLEN-1:0]     branch_target;
    logic                dc_valid;
    logic [BUNDLE_W-1:0] dc_bundle;
    logic [XLEN-1:0]     dc_pc;

    modport master (
        output imem_req_valid, imem_req_addr, dc_valid, dc_bundle, dc_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_bundle,
               stall_in, squash_in, branch_target
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dc_valid, dc_bundle, dc_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_bundle,
               stall_in, squash_in, branch_target
    );
endinterface

// File: rtl/vliw_fetch_unit.sv
// VLIW fetch stage: credit-limited bundle fetch, small bundle queue, squash redirect.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
//
// state | meaning
// BOOT  | single idle cycle after reset, no requests
// RUN   | normal fetch; redirects are handled here
module vliw_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              BUNDLE_W = 96,
    parameter int              QDEPTH   = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    vliw_fetch_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_squash_count
`endif
);
    localparam int              CW      = $clog2(QDEPTH) + 1;
    localparam int              PW      = $clog2(QDEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(BUNDLE_W / 8);
    localparam logic [CW:0]     QD      = (CW + 1)'(QDEPTH);

    typedef enum logic {BOOT, RUN} state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0]     fetch_pc;
    logic [CW-1:0]       q_count, inflight, drop_cnt;
    logic [PW-1:0]       q_rd, q_wr, pf_rd, pf_wr;
    logic [BUNDLE_W-1:0] q_bundle [QDEPTH];
    logic [XLEN-1:0]     q_pc     [QDEPTH];
    logic [XLEN-1:0]     pf_pc    [QDEPTH];

    logic req_valid, dc_valid_c;
    logic accept, pop, rsp, keep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_valid  = 1'b0;
        dc_valid_c = (q_count != '0) && !bus.squash_in;
        case (state)
            BOOT: state_nxt = RUN;
            RUN:  req_valid = !bus.squash_in &&
                              (({1'b0, q_count} + {1'b0, inflight}) < QD);
            default: state_nxt = BOOT;
        endcase
    end

    assign accept = req_valid && bus.imem_req_ready;
    assign pop    = dc_valid_c && !bus.stall_in;
    assign rsp    = bus.imem_rsp_valid;
    // Responses owed to a squashed path, or arriving in the squash cycle, never enter the queue.
    assign keep   = rsp && !bus.squash_in && (drop_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            q_count  <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            pf_rd    <= '0;
            pf_wr    <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(rsp);
            // The PC FIFO keeps tracking dropped responses so it stays aligned.
            if (accept) pf_wr <= pf_wr + 1'b1;
            if (rsp)    pf_rd <= pf_rd + 1'b1;
            if (bus.squash_in) begin
                fetch_pc <= bus.branch_target;
                drop_cnt <= inflight - CW'(rsp);
                q_count  <= '0;
                q_rd     <= '0;
                q_wr     <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + PC_STEP;
                if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
                if (keep) q_wr <= q_wr + 1'b1;
                if (pop)  q_rd <= q_rd + 1'b1;
                q_count <= q_count + CW'(keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) pf_pc[pf_wr] <= fetch_pc;
        if (keep) begin
            q_bundle[q_wr] <= bus.imem_rsp_bundle;
            q_pc[q_wr]     <= pf_pc[pf_rd];
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.dc_valid       = dc_valid_c;
    assign bus.dc_bundle      = dc_valid_c ? q_bundle[q_rd] : '0;
    assign bus.dc_pc          = dc_valid_c ? q_pc[q_rd] : '0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_squash_count <= '0;
        end else begin
            if (dc_valid_c && bus.stall_in && perf_stall_cycles != 32'hFFFF_FFFF)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (bus.squash_in && perf_squash_count != 32'hFFFF_FFFF)
                perf_squash_count <= perf_squash_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Scoreboard bench for vliw_fetch_unit: random-latency in-order memory,
// random stall/squash/ready, program-order reference of expected PCs.
module tb_vliw_fetch_unit;
    localparam int          XLEN   = 32;
    localparam int          BW     = 96;
    localparam int          QDEPTH = 2;
    localparam logic [31:0] STEP   = 32'd12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vliw_fetch_if #(.XLEN(XLEN), .BUNDLE_W(BW)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cycles, perf_squash_count;
`endif

    vliw_fetch_unit #(.XLEN(XLEN), .BUNDLE_W(BW), .QDEPTH(QDEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_squash_count(perf_squash_count)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat_max = 1;
    int          n_pops = 0;
    int          post = 0;
    logic [31:0] exp_req = 32'h0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          m_stall = 0;
    int          m_squash = 0;

    function automatic logic [95:0] bundle_of(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, ~a, a + 32'h1234_5679};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instruction memory: in-order, latency 1..lat_max, one response per cycle.
    initial begin
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_bundle = '0;
        forever begin
            mreq_t m;
            @(posedge clk);
            cyc++;
            #1;
            bus.imem_rsp_valid  = 1'b0;
            bus.imem_rsp_bundle = '0;
            if (rst) mem_q.delete();
            else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                m = mem_q.pop_front();
                bus.imem_rsp_valid  = 1'b1;
                bus.imem_rsp_bundle = bundle_of(m.addr);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.imem_req_valid && bus.imem_req_ready)
                mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + $urandom_range(1, lat_max)});
            check("credit_limit", {95'b0, mem_q.size() <= QDEPTH}, 96'd1);
        end
    end

    // Monitor: compares DUT outputs against the program-order scoreboard.
    always @(negedge clk) begin
        logic [31:0] p;
        if (rst) begin
            check("rst_req_valid", {95'b0, bus.imem_req_valid}, 96'd0);
            check("rst_dc_valid", {95'b0, bus.dc_valid}, 96'd0);
            check("rst_dc_bundle", bus.dc_bundle, 96'd0);
            check("rst_dc_pc", {64'b0, bus.dc_pc}, 96'd0);
`ifdef FETCH_PERF_EN
            check("rst_perf_stall", {64'b0, perf_stall_cycles}, 96'd0);
            check("rst_perf_squash", {64'b0, perf_squash_count}, 96'd0);
`endif
            post      = 0;
            exp_req   = 32'h0;
            prev_wait = 1'b0;
            m_stall   = 0;
            m_squash  = 0;
        end else begin
            if (post == 0) check("boot_no_req", {95'b0, bus.imem_req_valid}, 96'd0);
            if (post == 1) check("first_req", {95'b0, bus.imem_req_valid}, 96'd1);
            if (bus.squash_in) begin
                check("squash_dc_valid", {95'b0, bus.dc_valid}, 96'd0);
                check("squash_req_valid", {95'b0, bus.imem_req_valid}, 96'd0);
            end
            if (!bus.dc_valid) check("nop_bundle", bus.dc_bundle, 96'd0);
            if (prev_wait && !bus.squash_in) begin
                check("req_hold_valid", {95'b0, bus.imem_req_valid}, 96'd1);
                check("req_hold_addr", {64'b0, bus.imem_req_addr}, {64'b0, prev_addr});
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                check("req_addr", {64'b0, bus.imem_req_addr}, {64'b0, exp_req});
                exp_req = exp_req + STEP;
            end
            if (bus.dc_valid) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_nonempty", 96'd0, 96'd1);
                end else begin
                    check("dc_pc", {64'b0, bus.dc_pc}, {64'b0, exp_q[0]});
                    check("dc_bundle", bus.dc_bundle, bundle_of(exp_q[0]));
                    if (!bus.stall_in) begin
                        p = exp_q.pop_front();
                        if (exp_q.size() == 0) exp_q.push_back(p + STEP);
                        n_pops++;
                    end
                end
                if (bus.stall_in) m_stall++;
            end
            if (bus.squash_in) begin
                exp_req = bus.branch_target;
                m_squash++;
            end
            prev_wait = bus.imem_req_valid && !bus.imem_req_ready;
            prev_addr = bus.imem_req_addr;
            post++;
        end
    end

    task automatic step(input bit st, input bit sq, input logic [31:0] tgt, input bit rdy);
        @(posedge clk);
        #1;
        bus.stall_in       = st;
        bus.squash_in      = sq;
        bus.branch_target  = tgt;
        bus.imem_req_ready = rdy;
        if (sq) begin
            exp_q.delete();
            exp_q.push_back(tgt);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst                = 1'b1;
        bus.stall_in       = 1'b0;
        bus.squash_in      = 1'b0;
        bus.branch_target  = '0;
        bus.imem_req_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
    endtask

    task automatic random_run(input int n);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFE8 : $urandom;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, t,
                 $urandom_range(0, 9) < 7);
        end
    endtask

    initial begin
        bus.stall_in       = 1'b0;
        bus.squash_in      = 1'b0;
        bus.branch_target  = '0;
        bus.imem_req_ready = 1'b1;
        exp_q.push_back(32'h0);
        do_reset();
        repeat (8) step(0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 1);
        repeat (4) step(0, 0, 0, 1);
        step(0, 1, 32'h100, 1);
        repeat (6) step(0, 0, 0, 1);
        step(1, 1, 32'h200, 1);
        repeat (6) step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 1);
        lat_max = 3;
        random_run(3000);
        do_reset();
        random_run(500);
        step(0, 0, 0, 1);
        @(negedge clk);
        #1;
        check("progress", {95'b0, n_pops > 300}, 96'd1);
`ifdef FETCH_PERF_EN
        check("perf_stall", {64'b0, perf_stall_cycles}, {64'b0, 32'(m_stall)});
        check("perf_squash", {64'b0, perf_squash_count}, {64'b0, 32'(m_squash)});
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vliw_fetch_unit.md
Name: vliw_fetch_unit

Overview:
- Fetch stage directly upstream of decode and of the hazard detection unit.
- Generates bundle PCs and issues instruction-memory requests. Buffers returned 3-slot bundles (ixu1, ixu2, lsu) in a small queue and presents them to decode.
- Holds on the load-use stall from hazard detection.
- On a taken-branch squash: flushes its queue, discards in-flight responses and redirects to the branch target.

Parameters:
- XLEN, 32, address width.
- BUNDLE_W, 96, bundle width: 3 slots × 32 bits; the PC step is BUNDLE_W/8 = 12.
- QDEPTH, 2, bundle queue entries, power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  request to instruction memory.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  XLEN  bundle address, equal to the fetch PC.
- imem_rsp_valid  input  1  response bundle valid; responses return in order, latency ≥1.
- imem_rsp_bundle  input  BUNDLE_W  returned bundle.
- stall_in  input  1  load-use stall from hazard detection.
- squash_in  input  1  taken-branch squash from hazard detection.
- branch_target  input  XLEN  redirect PC, sampled when squash_in=1.
- dc_valid  output  1  a bundle is presented to decode.
- dc_bundle  output  BUNDLE_W  bundle to decode; all zeros (NOP) when dc_valid=0.
- dc_pc  output  XLEN  PC of dc_bundle.

Behaviour:
- Reset (async, active-high):
  - fetch_pc=RESET_PC; queue empty; inflight=0; drop_cnt=0; state=BOOT.
  - Outputs: imem_req_valid=0, dc_valid=0, dc_bundle=0, dc_pc=0.
  - Reset mid-operation abandons all state; instruction memory is reset by the same rst.
- FSM:
  - BOOT: one cycle with no requests, then RUN.
  - RUN: normal fetch.
  - No other states; redirect is handled within RUN.
- Issue rule:
  - imem_req_valid=1 iff state=RUN && !squash_in && (q_count + inflight) < QDEPTH.
  - The request is accepted when imem_req_valid && imem_req_ready.
  - On accept: fetch_pc += 12 (mod 2^XLEN, wraps silently) and inflight += 1.
- Response:
  - Every imem_rsp_valid decrements inflight.
  - If drop_cnt>0, the response is discarded and drop_cnt -= 1.
  - Otherwise it is pushed into the queue with its PC. The PC is tracked per in-flight slot via a small PC FIFO of depth QDEPTH.
  - The credit rule guarantees the queue never overflows; no backpressure on responses.
- Decode output:
  - dc_valid = queue not empty && !squash_in.
  - dc_bundle and dc_pc come from the queue head, combinationally.
  - Pop when dc_valid && !stall_in.
  - On stall, the head is held unchanged, and is held for any number of cycles.
- Squash (squash_in=1), with priority over stall and over all other events:
  - dc_valid=0 in the same cycle, so decode sees a NOP.
  - Queue flushed at the edge.
  - drop_cnt = number of requests still outstanding after this cycle. This includes a response arriving in the squash cycle, which is itself dropped.
  - fetch_pc = branch_target.
  - No request is issued in the squash cycle; the first request at branch_target goes out the next cycle at the earliest.
- Simultaneous events:
  - Squash with stall: squash wins.
  - Squash with response: response dropped.
  - Push and pop in the same cycle: allowed, q_count unchanged.
  - A second squash while drop_cnt>0: drop_cnt is recomputed from current inflight; no double counting.
- Internal sizing: counters are $clog2(QDEPTH)+1 bits wide.
- Memory protocol requirement: imem_req_addr is stable while imem_req_valid=1 && !imem_req_ready.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_squash_count[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - perf_stall_cycles increments on cycles with dc_valid && stall_in.
  - perf_squash_count increments on each cycle with squash_in=1.
- Undefined: ports and counters are absent; fetch behaviour is identical.

Test Plan:
- Reset, then 1-cycle-latency memory always ready, no stall or squash:
  - First request one cycle after BOOT, addr 0x0, then 0xC, 0x18.
  - dc_pc sequence 0x0, 0xC, 0x18 with dc_valid steady at 1 from the 3rd cycle.
- stall_in=1 for 3 cycles with bundle at 0x18 at the head:
  - dc_pc stays 0x18 and dc_bundle unchanged for all 3 cycles.
  - No request issued once q_count+inflight=2.
  - 0x24 follows the cycle after stall drops.
- squash_in=1 with branch_target=0x100 and 1 request in flight:
  - dc_valid=0 that cycle.
  - The in-flight response is discarded.
  - The next request address is 0x100; the next dc_pc is 0x100.
- squash_in and stall_in asserted together:
  - Squash behaviour as above; the stall has no effect.
- imem_req_ready=0 for 4 cycles:
  - imem_req_addr held constant and imem_req_valid held at 1.
  - fetch_pc advances by exactly 12 after the accept.
- With FETCH_PERF_EN, 5 stall cycles and 2 squashes: perf_stall_cycles=5, perf_squash_count=2; both read 0 after rst.
